// File: rtl/run_control.sv
// run_control: per-core fetch gating with drain-to-finish sequencing, watchdog
// and retire-accounting error detection for the multi-copy simulation harness.
module run_control #(
    parameter int NUM_CORES       = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int CNT_WIDTH       = 16,
    parameter int MAX_INSTR_COUNT = 32,
    parameter logic [ADDR_WIDTH-1:0] MAX_INSTR_ADDR = 16'hFFFF,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CORES-1:0]             fetch_i,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  instr_addr_i,
    input  logic [NUM_CORES-1:0]             retire_i,
    output logic [NUM_CORES-1:0]             enable_o,
    output logic [NUM_CORES-1:0]             addr_exit_o,
    output logic                             finished_o,
    output logic                             timeout_o,
    output logic                             error_o
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INSTR_COUNT);
    localparam int WD_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(WD_LAST_I);
    localparam logic WD_ON = (TIMEOUT_CYCLES != 0);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   fetch_cnt_q [NUM_CORES];
    logic [CNT_WIDTH-1:0]   fetch_cnt_d [NUM_CORES];
    logic [CNT_WIDTH-1:0]   retire_cnt_q [NUM_CORES];
    logic [CNT_WIDTH-1:0]   retire_cnt_d [NUM_CORES];
    logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CORES-1:0]   enable_q, enable_d, addr_exit_q, addr_exit_d;
    logic                   finished_q, finished_d, timeout_q, timeout_d, error_q, error_d;
    logic [NUM_CORES-1:0]   accept, in_range, at_cap, retire_ok, matched;
    logic                   live, clean, wd_hit, all_off;

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
        assign in_range[k] = instr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] <= MAX_INSTR_ADDR;
    end

    assign live   = (state_q != DONE);
    assign accept = enable_q & fetch_i;

    always_comb begin
        at_cap    = '0;
        retire_ok = '0;
        matched   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            fetch_cnt_d[k]  = fetch_cnt_q[k] + CNT_WIDTH'(accept[k] & in_range[k]);
            at_cap[k]       = (fetch_cnt_d[k] == MAX_CNT);
            // a retire may consume a fetch accepted on the same edge
            retire_ok[k]    = live & retire_i[k] & (retire_cnt_q[k] < fetch_cnt_d[k]);
            retire_cnt_d[k] = retire_cnt_q[k] + CNT_WIDTH'(retire_ok[k]);
            matched[k]      = (retire_cnt_d[k] == fetch_cnt_d[k]);
        end
        all_off     = ~|(enable_q & ~(accept & (~in_range | at_cap)));
        clean       = live & all_off & (&matched);
        wd_hit      = live & WD_ON & (cycle_cnt_q >= WD_LAST);
        state_d     = !live ? DONE : (clean | wd_hit) ? DONE : all_off ? DRAIN : RUN;
        enable_d    = (state_d == DONE) ? '0 : enable_q & ~(accept & (~in_range | at_cap));
        addr_exit_d = addr_exit_q | (accept & ~in_range);
        error_d     = error_q | (live & |(retire_i & ~retire_ok));
        finished_d  = finished_q | clean | wd_hit;
        timeout_d   = timeout_q | (wd_hit & ~clean);
        cycle_cnt_d = (live && cycle_cnt_q != '1) ? cycle_cnt_q + 1'b1 : cycle_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            enable_q    <= '1;
            addr_exit_q <= '0;
            finished_q  <= 1'b0;
            timeout_q   <= 1'b0;
            error_q     <= 1'b0;
            cycle_cnt_q <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                fetch_cnt_q[k]  <= '0;
                retire_cnt_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            addr_exit_q <= addr_exit_d;
            finished_q  <= finished_d;
            timeout_q   <= timeout_d;
            error_q     <= error_d;
            cycle_cnt_q <= cycle_cnt_d;
            for (int k = 0; k < NUM_CORES; k++) begin
                fetch_cnt_q[k]  <= fetch_cnt_d[k];
                retire_cnt_q[k] <= retire_cnt_d[k];
            end
        end
    end

    assign enable_o    = enable_q;
    assign addr_exit_o = addr_exit_q;
    assign finished_o  = finished_q;
    assign timeout_o   = timeout_q;
    assign error_o     = error_q;
endmodule

// File: tb/tb_run_control.sv
// tb_run_control: directed plus random stimulus for run_control, checked
// against a behavioural model of the run rules (2 cores, limit 4, addr <= 0xFF, watchdog 20).
module tb_run_control;
    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  fetch_i, retire_i;
    logic [31:0] instr_addr_i;
    logic [1:0]  enable_o, addr_exit_o;
    logic        finished_o, timeout_o, error_o;

    int total = 0;
    int bad = 0;

    logic [1:0] m_en, m_ax;
    logic       m_fin, m_to, m_err, m_done;
    int         m_fc [2];
    int         m_rc [2];
    int         m_cyc;

    run_control #(
        .NUM_CORES(2), .ADDR_WIDTH(16), .CNT_WIDTH(16), .MAX_INSTR_COUNT(4),
        .MAX_INSTR_ADDR(16'h00FF), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .fetch_i(fetch_i), .instr_addr_i(instr_addr_i),
        .retire_i(retire_i), .enable_o(enable_o), .addr_exit_o(addr_exit_o),
        .finished_o(finished_o), .timeout_o(timeout_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic ck(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [15:0] a;
        if (rst_i) begin
            m_en = 2'b11; m_ax = 2'b00; m_fin = 0; m_to = 0; m_err = 0; m_done = 0;
            m_fc = '{0, 0}; m_rc = '{0, 0}; m_cyc = 0;
        end else if (!m_done) begin
            for (int k = 0; k < 2; k++) begin
                a = instr_addr_i[k*16 +: 16];
                if (m_en[k] && fetch_i[k]) begin
                    if (a <= 16'h00FF) begin
                        m_fc[k]++;
                        if (m_fc[k] == 4) m_en[k] = 1'b0;
                    end else begin
                        m_en[k] = 1'b0;
                        m_ax[k] = 1'b1;
                    end
                end
                if (retire_i[k]) begin
                    if (m_rc[k] < m_fc[k]) m_rc[k]++;
                    else m_err = 1'b1;
                end
            end
            if (m_en == 2'b00 && m_fc[0] == m_rc[0] && m_fc[1] == m_rc[1]) begin
                m_done = 1; m_fin = 1;
            end else if (m_cyc >= 19) begin
                m_done = 1; m_fin = 1; m_to = 1; m_en = 2'b00;
            end
            if (m_cyc < 65535) m_cyc++;
        end
    endtask

    task automatic step(input string tag, input logic [1:0] f, input logic [15:0] a0,
                        input logic [15:0] a1, input logic [1:0] r, input logic rs);
        fetch_i = f; instr_addr_i = {a1, a0}; retire_i = r; rst_i = rs;
        @(posedge clk);
        model_edge();
        #1;
        ck({tag, ".enable"}, enable_o, m_en);
        ck({tag, ".addr_exit"}, addr_exit_o, m_ax);
        ck({tag, ".finished"}, {1'b0, finished_o}, {1'b0, m_fin});
        ck({tag, ".timeout"}, {1'b0, timeout_o}, {1'b0, m_to});
        ck({tag, ".error"}, {1'b0, error_o}, {1'b0, m_err});
    endtask

    initial begin
        // reset values
        step("rst", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        ck("rst_en", enable_o, 2'b11);
        ck("rst_fin", {1'b0, finished_o}, 2'b00);
        // core 0 hits its fetch limit, then core 1, then both drain
        for (int i = 0; i < 4; i++) step("c0f", 2'b01, 16'(16'h10 + i), 16'h0, 2'b00, 1'b0);
        ck("c0_lim_en", enable_o, 2'b10);
        ck("c0_lim_fin", {1'b0, finished_o}, 2'b00);
        for (int i = 0; i < 4; i++) step("c1f", 2'b10, 16'h0, 16'(16'h20 + i), 2'b00, 1'b0);
        ck("drain_en", enable_o, 2'b00);
        for (int i = 0; i < 3; i++) step("ret", 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
        ck("drain_notfin", {1'b0, finished_o}, 2'b00);
        step("ret_last", 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
        ck("clean_fin", {1'b0, finished_o}, 2'b01);
        ck("clean_to", {1'b0, timeout_o}, 2'b00);
        ck("clean_err", {1'b0, error_o}, 2'b00);
        // out-of-range exit on core 1; simultaneous fetch+retire on core 0
        step("rst2", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        step("c1g", 2'b10, 16'h0, 16'h0020, 2'b00, 1'b0);
        step("c1g", 2'b10, 16'h0, 16'h00FF, 2'b00, 1'b0);
        step("c1x", 2'b10, 16'h0, 16'h0100, 2'b00, 1'b0);
        ck("exit_en", enable_o, 2'b01);
        ck("exit_ax", addr_exit_o, 2'b10);
        for (int i = 0; i < 4; i++) step("c0fr", 2'b01, 16'h0030, 16'h0, 2'b01, 1'b0);
        ck("fr_err", {1'b0, error_o}, 2'b00);
        step("c1r", 2'b00, 16'h0, 16'h0, 2'b10, 1'b0);
        ck("c1r_notfin", {1'b0, finished_o}, 2'b00);
        step("c1r", 2'b00, 16'h0, 16'h0, 2'b10, 1'b0);
        ck("exit_fin", {1'b0, finished_o}, 2'b01);
        // unmatched retire sets sticky error
        step("rst3", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        step("bad_ret", 2'b00, 16'h0, 16'h0, 2'b01, 1'b0);
        ck("err_set", {1'b0, error_o}, 2'b01);
        step("idle", 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
        ck("err_sticky", {1'b0, error_o}, 2'b01);
        // watchdog: fetches never retired
        step("rst4", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        step("wf", 2'b11, 16'h0010, 16'h0010, 2'b00, 1'b0);
        step("wf", 2'b11, 16'h0011, 16'h0011, 2'b00, 1'b0);
        for (int i = 3; i < 20; i++) step("widle", 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
        ck("wd19_fin", {1'b0, finished_o}, 2'b00);
        step("w20", 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
        ck("wd20_fin", {1'b0, finished_o}, 2'b01);
        ck("wd20_to", {1'b0, timeout_o}, 2'b01);
        ck("wd20_en", enable_o, 2'b00);
        for (int i = 0; i < 3; i++) step("done_ret", 2'b01, 16'h0, 16'h0, 2'b01, 1'b0);
        ck("done_noerr", {1'b0, error_o}, 2'b00);
        // reset during DRAIN, then a full clean run
        step("rst5", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step("df", 2'b11, 16'h0040, 16'h0041, 2'b00, 1'b0);
        step("dr", 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
        step("drst", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
        ck("drst_en", enable_o, 2'b11);
        ck("drst_flags", {finished_o, error_o}, 2'b00);
        for (int i = 0; i < 4; i++) step("rf", 2'b11, 16'h0050, 16'h0051, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) step("rr", 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
        ck("rerun_fin", {timeout_o, finished_o}, 2'b01);
        // random runs
        for (int run = 0; run < 15; run++) begin
            step("rrst", 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
            for (int i = 0; i < 40; i++) begin
                logic [15:0] a0, a1;
                a0 = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h0100, 16'hFFFF)) : 16'($urandom_range(0, 255));
                a1 = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'h0100, 16'hFFFF)) : 16'($urandom_range(0, 255));
                step("rnd", 2'($urandom), a0, a1, 2'($urandom), ($urandom_range(0, 59) == 0));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
